// File: rtl/axi_common_types_pkg.sv
// Shared AXI widths, response/burst encodings and the write-endpoint state
// type used by the NoC slave-side blocks.
package axi_common_types_pkg;

  localparam int AXI_ID_WIDTH    = 4;
  localparam int AXI_ADDR_WIDTH  = 32;
  localparam int AXI_LEN_WIDTH   = 4;
  localparam int AXI_SIZE_WIDTH  = 3;
  localparam int AXI_BURST_WIDTH = 2;
  localparam int AXI_RESP_WIDTH  = 2;
  localparam int AXI_DATA_WIDTH  = 32;

  localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'd0;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'd2;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_DECERR = 2'd3;

  localparam logic [AXI_BURST_WIDTH-1:0] BURST_FIXED = 2'd0;
  localparam logic [AXI_BURST_WIDTH-1:0] BURST_INCR  = 2'd1;
  localparam logic [AXI_BURST_WIDTH-1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address step.
// Ports:
//   addr, len, size, burst : current beat address and burst descriptor
//   next_addr              : address of the following beat (FIXED/INCR/WRAP)
//   wrap_ok                : WRAP descriptor is legal (len+1 in {2,4,8,16},
//                            addr aligned to the beat size)
module axi_burst_addr_gen
  import axi_common_types_pkg::*;
(
  input  logic [AXI_ADDR_WIDTH-1:0]  addr,
  input  logic [AXI_LEN_WIDTH-1:0]   len,
  input  logic [AXI_SIZE_WIDTH-1:0]  size,
  input  logic [AXI_BURST_WIDTH-1:0] burst,
  output logic [AXI_ADDR_WIDTH-1:0]  next_addr,
  output logic                       wrap_ok
);

  logic [AXI_ADDR_WIDTH-1:0] step;
  logic [AXI_ADDR_WIDTH-1:0] incr_addr;
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
  logic [AXI_LEN_WIDTH-1:0]  len_p1;

  always_comb begin
    step      = AXI_ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Container is (len+1) beats of 2^size bytes; the mask selects the
    // address bits that wrap inside it.
    wrap_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
    len_p1    = len + AXI_LEN_WIDTH'(1);

    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase

    // len+1 must be a power of two greater than one; len=15 wraps len_p1 to 0.
    wrap_ok = (len != '0) && ((len & len_p1) == '0) &&
              ((addr & (step - AXI_ADDR_WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/axi_slave_wr_endpoint.sv
// Slave-side AXI write endpoint: accepts one AW burst at a time, commits W
// beats into a local word memory and returns one B response per burst.
// Ports:
//   ACLK, ARESET      : clock, synchronous active-high reset
//   S_AW*             : write address channel (ID, ADDR, LEN, SIZE, BURST)
//   S_W*              : write data channel (DATA, STRB, LAST)
//   S_B*              : write response channel (ID, RESP)
//   dbg_addr/dbg_rdata: backdoor combinational read of one memory word
//   dbg_state         : current FSM state
//
// Handshakes: a transfer happens on a rising ACLK edge where both VALID and
// READY are high. READY/VALID outputs here are registered and never depend
// on the partner's VALID/READY in the same cycle; B outputs stay stable
// from BVALID rising until the BREADY handshake.
module axi_slave_wr_endpoint
  import axi_common_types_pkg::*;
#(
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = AXI_DATA_WIDTH,
  localparam int STRB_W   = DATA_W / 8,
  localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXI_ID_WIDTH-1:0]    S_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]  S_AWADDR,
  input  logic [AXI_LEN_WIDTH-1:0]   S_AWLEN,
  input  logic [AXI_SIZE_WIDTH-1:0]  S_AWSIZE,
  input  logic [AXI_BURST_WIDTH-1:0] S_AWBURST,
  input  logic                       S_AWVALID,
  output logic                       S_AWREADY,
  input  logic [DATA_W-1:0]          S_WDATA,
  input  logic [STRB_W-1:0]          S_WSTRB,
  input  logic                       S_WLAST,
  input  logic                       S_WVALID,
  output logic                       S_WREADY,
  output logic [AXI_ID_WIDTH-1:0]    S_BID,
  output logic [AXI_RESP_WIDTH-1:0]  S_BRESP,
  output logic                       S_BVALID,
  input  logic                       S_BREADY,
  input  logic [IDX_W-1:0]           dbg_addr,
  output logic [DATA_W-1:0]          dbg_rdata,
  output wr_state_e                  dbg_state
);

  localparam int LANE_SHIFT = $clog2(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(MEM_DEPTH * STRB_W);

  wr_state_e                  state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]    id_q;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q;
  logic [AXI_LEN_WIDTH-1:0]   len_q, cnt_q;
  logic [AXI_SIZE_WIDTH-1:0]  size_q;
  logic [AXI_BURST_WIDTH-1:0] burst_q;
  logic                       burst_err_q, wlast_err_q, decerr_q;
  logic                       awready_q, wready_q, bvalid_q;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic                       aw_hs, w_hs, b_hs, last_beat, in_range, mem_we, aw_err;
  logic [AXI_ADDR_WIDTH-1:0]  offset;
  logic [IDX_W-1:0]           word_idx;
  logic [AXI_ADDR_WIDTH-1:0]  gen_addr, gen_next;
  logic [AXI_LEN_WIDTH-1:0]   gen_len;
  logic [AXI_SIZE_WIDTH-1:0]  gen_size;
  logic [AXI_BURST_WIDTH-1:0] gen_burst;
  logic                       gen_wrap_ok;

  // In IDLE the generator looks at the incoming AW so the WRAP legality
  // check can be latched at the handshake; afterwards it steps the
  // captured burst.
  assign gen_addr  = (state_q == IDLE) ? S_AWADDR  : addr_q;
  assign gen_len   = (state_q == IDLE) ? S_AWLEN   : len_q;
  assign gen_size  = (state_q == IDLE) ? S_AWSIZE  : size_q;
  assign gen_burst = (state_q == IDLE) ? S_AWBURST : burst_q;

  axi_burst_addr_gen u_addr_gen (
    .addr      (gen_addr),
    .len       (gen_len),
    .size      (gen_size),
    .burst     (gen_burst),
    .next_addr (gen_next),
    .wrap_ok   (gen_wrap_ok)
  );

  assign aw_hs     = S_AWVALID & awready_q;
  assign w_hs      = S_WVALID & wready_q;
  assign b_hs      = bvalid_q & S_BREADY;
  assign last_beat = (cnt_q == len_q);

  // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned
  // compare covers both ends of the window.
  assign offset    = addr_q - BASE_ADDR;
  assign in_range  = (offset < SPAN);
  assign word_idx  = offset[LANE_SHIFT +: IDX_W];
  assign mem_we    = w_hs & in_range & ~burst_err_q & ~ARESET;

  assign aw_err = (S_AWSIZE > AXI_SIZE_WIDTH'(LANE_SHIFT)) ||
                  (S_AWBURST == 2'd3) ||
                  ((S_AWBURST == BURST_WRAP) && !gen_wrap_ok);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
      wlast_err_q <= 1'b0;
      decerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == IDLE);
      wready_q  <= (state_d == DATA);
      bvalid_q  <= (state_d == RESP);
      if (aw_hs) begin
        id_q        <= S_AWID;
        addr_q      <= S_AWADDR;
        len_q       <= S_AWLEN;
        size_q      <= S_AWSIZE;
        burst_q     <= S_AWBURST;
        cnt_q       <= '0;
        burst_err_q <= aw_err;
        wlast_err_q <= 1'b0;
        decerr_q    <= 1'b0;
      end
      if (w_hs) begin
        addr_q <= gen_next;
        cnt_q  <= cnt_q + AXI_LEN_WIDTH'(1);
        if (!in_range) decerr_q <= 1'b1;
        if (S_WLAST != last_beat) wlast_err_q <= 1'b1;
      end
    end
  end

  // Memory contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_WSTRB[b]) mem[word_idx][b*8 +: 8] <= S_WDATA[b*8 +: 8];
      end
    end
  end

  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BVALID  = bvalid_q;
  assign S_BID     = id_q;
  assign S_BRESP   = decerr_q ? RESP_DECERR :
                     (burst_err_q | wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign dbg_rdata = mem[dbg_addr];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_slave_wr_endpoint.sv
// Directed bench for axi_slave_wr_endpoint: a table of bursts with expected
// responses and expected memory words, plus hand-written reset sequences.
module tb_axi_slave_wr_endpoint;
  import axi_common_types_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  S_AWID;
  logic [31:0] S_AWADDR;
  logic [3:0]  S_AWLEN;
  logic [2:0]  S_AWSIZE;
  logic [1:0]  S_AWBURST;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WLAST;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [3:0]  S_BID;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  wr_state_e   dbg_state;

  axi_slave_wr_endpoint dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .S_AWID    (S_AWID),
    .S_AWADDR  (S_AWADDR),
    .S_AWLEN   (S_AWLEN),
    .S_AWSIZE  (S_AWSIZE),
    .S_AWBURST (S_AWBURST),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_WLAST   (S_WLAST),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BID     (S_BID),
    .S_BRESP   (S_BRESP),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tables ----------------
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data0;    // beat b carries data0 + b
    logic [3:0]  strb1;    // strobe for beat 1, other beats use 4'hF
    logic [3:0]  last_at;  // beat index that carries WLAST
    logic [3:0]  bdelay;   // cycles BREADY is held low after BVALID
    logic [1:0]  resp;
  } vec_t;

  typedef struct packed {
    logic [7:0]  vec;
    logic [7:0]  idx;
    logic [31:0] val;
  } mchk_t;

  vec_t  vecs[$];
  mchk_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk_vec(input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [2:0] size,
                                  input logic [1:0] burst, input logic [31:0] data0,
                                  input logic [3:0] strb1, input logic [3:0] last_at,
                                  input logic [3:0] bdelay, input logic [1:0] resp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.data0 = data0; v.strb1 = strb1; v.last_at = last_at; v.bdelay = bdelay;
    v.resp = resp;
    return v;
  endfunction

  function automatic mchk_t mk_chk(input logic [7:0] vec, input logic [7:0] idx,
                                   input logic [31:0] val);
    mchk_t c;
    c.vec = vec; c.idx = idx; c.val = val;
    return c;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_mem(input logic [7:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("mem[%0d]", idx), dbg_rdata, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = size; S_AWBURST = burst;
    S_AWVALID = 1'b1;
    n = 0;
    while (S_AWREADY !== 1'b1 && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("aw_ready_wait", 32'(S_AWREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0;
    check("w_ready_after_aw", 32'(S_WREADY), 32'd1);
    check("aw_ready_in_data", 32'(S_AWREADY), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    send_aw(v.id, v.addr, v.len, v.size, v.burst);
    for (int b = 0; b <= int'(v.len); b++) begin
      S_WDATA  = v.data0 + 32'(b);
      S_WSTRB  = (b == 1) ? v.strb1 : 4'hF;
      S_WLAST  = (b == int'(v.last_at));
      S_WVALID = 1'b1;
      check($sformatf("v%0d_no_b_before_beat%0d", vi, b), 32'(S_BVALID), 32'd0);
      @(posedge ACLK); #1;
    end
    S_WVALID = 1'b0;
    S_WLAST  = 1'b0;
    check($sformatf("v%0d_bvalid", vi), 32'(S_BVALID), 32'd1);
    check($sformatf("v%0d_wready_in_resp", vi), 32'(S_WREADY), 32'd0);
    check($sformatf("v%0d_bid", vi), 32'(S_BID), 32'(v.id));
    check($sformatf("v%0d_bresp", vi), 32'(S_BRESP), 32'(v.resp));
    for (int d = 0; d < int'(v.bdelay); d++) begin
      @(posedge ACLK); #1;
      check($sformatf("v%0d_hold_bvalid", vi), 32'(S_BVALID), 32'd1);
      check($sformatf("v%0d_hold_bid", vi), 32'(S_BID), 32'(v.id));
      check($sformatf("v%0d_hold_bresp", vi), 32'(S_BRESP), 32'(v.resp));
      check($sformatf("v%0d_hold_awready", vi), 32'(S_AWREADY), 32'd0);
    end
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
    check($sformatf("v%0d_bvalid_drop", vi), 32'(S_BVALID), 32'd0);
    check($sformatf("v%0d_awready_back", vi), 32'(S_AWREADY), 32'd1);
    foreach (exp_q[k]) begin
      if (int'(exp_q[k].vec) == vi) check_mem(exp_q[k].idx, exp_q[k].val);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    ARESET = 1'b1;
    S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    dbg_addr = '0;

    //              id    addr          len   size  burst data0          strb1 last  bdly  resp
    vecs.push_back(mk_vec(4'd2,  32'h000, 4'd0, 3'd2, 2'd1, 32'h0BADF00D, 4'hF, 4'd0, 4'd0, 2'd0));
    vecs.push_back(mk_vec(4'd1,  32'h024, 4'd0, 3'd2, 2'd1, 32'hA5A5A5A5, 4'hF, 4'd0, 4'd0, 2'd0));
    vecs.push_back(mk_vec(4'd3,  32'h010, 4'd0, 3'd2, 2'd1, 32'hDEADBEEF, 4'hF, 4'd0, 4'd0, 2'd0));
    vecs.push_back(mk_vec(4'd5,  32'h020, 4'd3, 3'd2, 2'd1, 32'h11110000, 4'h3, 4'd3, 4'd2, 2'd0));
    vecs.push_back(mk_vec(4'd6,  32'h038, 4'd3, 3'd2, 2'd2, 32'h22220000, 4'hF, 4'd3, 4'd0, 2'd0));
    vecs.push_back(mk_vec(4'd7,  32'h020, 4'd2, 3'd2, 2'd2, 32'h33330000, 4'hF, 4'd2, 4'd0, 2'd2));
    vecs.push_back(mk_vec(4'd9,  32'h3FC, 4'd1, 3'd2, 2'd1, 32'h44440000, 4'hF, 4'd1, 4'd0, 2'd3));
    vecs.push_back(mk_vec(4'd10, 32'h080, 4'd3, 3'd2, 2'd1, 32'h55550000, 4'hF, 4'd1, 4'd5, 2'd2));
    vecs.push_back(mk_vec(4'd12, 32'h010, 4'd0, 3'd2, 2'd3, 32'h66660000, 4'hF, 4'd0, 4'd0, 2'd2));
    vecs.push_back(mk_vec(4'd13, 32'h084, 4'd2, 3'd2, 2'd0, 32'h77770000, 4'hF, 4'd2, 4'd0, 2'd0));
    vecs.push_back(mk_vec(4'd11, 32'h000, 4'd0, 3'd3, 2'd1, 32'h99990000, 4'hF, 4'd0, 4'd0, 2'd2));
    vecs.push_back(mk_vec(4'd15, 32'h022, 4'd1, 3'd2, 2'd2, 32'hBBBB0000, 4'hF, 4'd1, 4'd0, 2'd2));
    vecs.push_back(mk_vec(4'd14, 32'h0C0, 4'd0, 3'd2, 2'd1, 32'hABCD0123, 4'hF, 4'd0, 4'd0, 2'd0));

    exp_q.push_back(mk_chk(8'd0,  8'd0,   32'h0BADF00D));
    exp_q.push_back(mk_chk(8'd1,  8'd9,   32'hA5A5A5A5));
    exp_q.push_back(mk_chk(8'd2,  8'd4,   32'hDEADBEEF));
    exp_q.push_back(mk_chk(8'd3,  8'd8,   32'h11110000));
    exp_q.push_back(mk_chk(8'd3,  8'd9,   32'hA5A50001));
    exp_q.push_back(mk_chk(8'd3,  8'd10,  32'h11110002));
    exp_q.push_back(mk_chk(8'd3,  8'd11,  32'h11110003));
    exp_q.push_back(mk_chk(8'd4,  8'd14,  32'h22220000));
    exp_q.push_back(mk_chk(8'd4,  8'd15,  32'h22220001));
    exp_q.push_back(mk_chk(8'd4,  8'd12,  32'h22220002));
    exp_q.push_back(mk_chk(8'd4,  8'd13,  32'h22220003));
    exp_q.push_back(mk_chk(8'd5,  8'd8,   32'h11110000));
    exp_q.push_back(mk_chk(8'd5,  8'd9,   32'hA5A50001));
    exp_q.push_back(mk_chk(8'd5,  8'd10,  32'h11110002));
    exp_q.push_back(mk_chk(8'd6,  8'd255, 32'h44440000));
    exp_q.push_back(mk_chk(8'd6,  8'd0,   32'h0BADF00D));
    exp_q.push_back(mk_chk(8'd7,  8'd32,  32'h55550000));
    exp_q.push_back(mk_chk(8'd7,  8'd33,  32'h55550001));
    exp_q.push_back(mk_chk(8'd7,  8'd34,  32'h55550002));
    exp_q.push_back(mk_chk(8'd7,  8'd35,  32'h55550003));
    exp_q.push_back(mk_chk(8'd8,  8'd4,   32'hDEADBEEF));
    exp_q.push_back(mk_chk(8'd9,  8'd33,  32'h77770002));
    exp_q.push_back(mk_chk(8'd9,  8'd34,  32'h55550002));
    exp_q.push_back(mk_chk(8'd10, 8'd0,   32'h0BADF00D));
    exp_q.push_back(mk_chk(8'd11, 8'd8,   32'h11110000));
    exp_q.push_back(mk_chk(8'd11, 8'd9,   32'hA5A50001));
    exp_q.push_back(mk_chk(8'd12, 8'd48,  32'hABCD0123));
    exp_q.push_back(mk_chk(8'd12, 8'd49,  32'h88880001));

    // Reset state.
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", 32'(S_AWREADY), 32'd0);
    check("rst_wready",  32'(S_WREADY),  32'd0);
    check("rst_bvalid",  32'(S_BVALID),  32'd0);
    check("rst_bid",     32'(S_BID),     32'd0);
    check("rst_bresp",   32'(S_BRESP),   32'd0);
    check("rst_state",   32'(dbg_state), 32'(IDLE));
    ARESET = 1'b0;
    #1;
    check("awready_before_first_edge", 32'(S_AWREADY), 32'd0);
    @(posedge ACLK); #1;
    check("awready_after_first_edge", 32'(S_AWREADY), 32'd1);

    for (int i = 0; i < vecs.size() - 1; i++) run_vec(vecs[i], i);

    // Reset after beat 2 of an 8-beat burst: no B, written beats persist.
    send_aw(4'd4, 32'h0C0, 4'd7, 3'd2, 2'd1);
    for (int b = 0; b < 3; b++) begin
      S_WDATA = 32'h88880000 + 32'(b); S_WSTRB = 4'hF; S_WLAST = 1'b0; S_WVALID = 1'b1;
      @(posedge ACLK); #1;
    end
    S_WVALID = 1'b0;
    check("midrst_no_b_before", 32'(S_BVALID), 32'd0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("midrst_bvalid",  32'(S_BVALID),  32'd0);
    check("midrst_awready", 32'(S_AWREADY), 32'd0);
    check("midrst_wready",  32'(S_WREADY),  32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("postrst_awready", 32'(S_AWREADY), 32'd1);
    check("postrst_bvalid",  32'(S_BVALID),  32'd0);
    check("postrst_wready",  32'(S_WREADY),  32'd0);
    check_mem(8'd48, 32'h88880000);
    check_mem(8'd49, 32'h88880001);
    check_mem(8'd50, 32'h88880002);

    run_vec(vecs[vecs.size() - 1], vecs.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
